// File: rtl/counter_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | counter_arb_pkg : shared types and sizes for the counter arbiter |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package counter_arb_pkg;

  localparam int NREQ   = 2;
  localparam int STEP_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [NREQ-1:0] owner_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_arbiter2 : two-way round-robin pick against last-served index |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module rr_arbiter2
  import counter_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic            last,
  output logic [NREQ-1:0] win
);

  always_comb begin
    win = '0;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      // On a tie the requester that was not served last goes first.
      2'b11:   win = last ? 2'b01 : 2'b10;
      default: win = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/up_down_counter_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | up_down_counter_arbiter : grants one requester at a time and     |
// | drives cnt_up/cnt_down for its latched step count.  Rev 1.0      |
// +------------------------------------------------------------------+
module up_down_counter_arbiter #(
  parameter int NREQ   = counter_arb_pkg::NREQ,
  parameter int STEP_W = counter_arb_pkg::STEP_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   dir,
  input  logic [STEP_W-1:0] steps0,
  input  logic [STEP_W-1:0] steps1,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic              cnt_up,
  output logic              cnt_down
);

  import counter_arb_pkg::*;

  state_t            r_state, w_state;
  logic              r_owner, w_owner;
  logic              r_dir,   w_dir;
  logic              r_last,  w_last;
  logic [STEP_W-1:0] r_rem,   w_rem;
  logic [NREQ-1:0]   r_gnt,   w_gnt;
  logic [NREQ-1:0]   r_done,  w_done;
  logic              r_busy,  w_busy;
  logic              r_up,    w_up;
  logic              r_down,  w_down;

  logic [NREQ-1:0]   w_win;
  logic [STEP_W-1:0] w_sel_steps;

  rr_arbiter2 u_rr (
    .req  (req),
    .last (r_last),
    .win  (w_win)
  );

  assign w_sel_steps = w_win[1] ? steps1 : steps0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_dir   <= 1'b0;
      r_last  <= 1'b1;
      r_rem   <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
      r_up    <= 1'b0;
      r_down  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_owner <= w_owner;
      r_dir   <= w_dir;
      r_last  <= w_last;
      r_rem   <= w_rem;
      r_gnt   <= w_gnt;
      r_done  <= w_done;
      r_busy  <= w_busy;
      r_up    <= w_up;
      r_down  <= w_down;
    end
  end

  always_comb begin
    w_state = r_state;
    w_owner = r_owner;
    w_dir   = r_dir;
    w_last  = r_last;
    w_rem   = r_rem;
    w_gnt   = '0;
    w_done  = '0;
    w_up    = 1'b0;
    w_down  = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_win) begin
          w_owner = w_win[1];
          w_dir   = |(dir & w_win);
          w_gnt   = w_win;
          if (w_sel_steps != '0) begin
            // First pulse rides with the grant, so the remainder starts at steps-1.
            w_state = RUN;
            w_rem   = w_sel_steps - STEP_W'(1);
            w_up    = w_dir;
            w_down  = ~w_dir;
          end else begin
            w_state = DONE;
            w_rem   = '0;
            w_last  = w_win[1];
          end
        end
      end
      RUN: begin
        if (r_rem != '0) begin
          w_rem  = r_rem - STEP_W'(1);
          w_up   = r_dir;
          w_down = ~r_dir;
        end else begin
          w_state = DONE;
          w_done  = owner_onehot(r_owner);
          w_last  = r_owner;
        end
      end
      DONE: begin
        // Entered straight from IDLE (zero steps): done has not fired yet.
        if (r_done != '0) begin
          w_state = IDLE;
        end else begin
          w_done = owner_onehot(r_owner);
        end
      end
      default: w_state = IDLE;
    endcase
    w_busy = (w_state != IDLE);
  end

  assign gnt      = r_gnt;
  assign done     = r_done;
  assign busy     = r_busy;
  assign cnt_up   = r_up;
  assign cnt_down = r_down;

endmodule
`default_nettype wire

// File: tb/tb_up_down_counter_arbiter.sv
`default_nettype none
// Bench for up_down_counter_arbiter: a 3-bit up/down counter fed by the
// arbiter, a slot-scheduled reference model, and directed scenarios.
module tb_up_down_counter_arbiter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] req = 2'b00;
  logic [1:0] dir = 2'b00;
  logic [2:0] steps0 = 3'd0;
  logic [2:0] steps1 = 3'd0;
  logic [1:0] gnt, done;
  logic       busy, cnt_up, cnt_down;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  up_down_counter_arbiter #(.NREQ(2), .STEP_W(3)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .dir      (dir),
    .steps0   (steps0),
    .steps1   (steps1),
    .gnt      (gnt),
    .done     (done),
    .busy     (busy),
    .cnt_up   (cnt_up),
    .cnt_down (cnt_down)
  );

  // The counter the arbiter drives (wraps naturally at 3 bits).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      count <= 3'd0;
    else if (cnt_up)   count <= count + 3'd1;
    else if (cnt_down) count <= count - 3'd1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: slot n is the cycle following the n-th rising edge.
  // A grant taken at edge n with s steps owns gnt at n, pulses n..n+s-1,
  // done right after the last pulse (or one cycle later for s=0), then one
  // idle cycle before the next request can be sampled.
  int n = 0;
  int free_at = 0;
  int last_m = 1;
  bit [1:0] e_gnt[int];
  bit [1:0] e_done[int];
  bit       e_up[int];
  bit       e_down[int];
  bit       e_busy[int];

  always @(posedge clk or negedge reset_n) begin : p_model
    int w, s, dslot;
    bit d;
    if (!reset_n) begin
      e_gnt.delete(); e_done.delete(); e_up.delete(); e_down.delete(); e_busy.delete();
      last_m  = 1;
      free_at = 0;
    end else begin
      n++;
      if (n >= free_at && req != 2'b00) begin
        if (req == 2'b11) w = (last_m == 0) ? 1 : 0;
        else              w = req[1] ? 1 : 0;
        s = (w == 1) ? int'(steps1) : int'(steps0);
        d = dir[w];
        e_gnt[n] = (w == 1) ? 2'b10 : 2'b01;
        for (int k = 0; k < s; k++) begin
          if (d) e_up[n+k] = 1'b1;
          else   e_down[n+k] = 1'b1;
        end
        dslot = (s == 0) ? n + 1 : n + s;
        e_done[dslot] = (w == 1) ? 2'b10 : 2'b01;
        for (int k = n; k <= dslot; k++) e_busy[k] = 1'b1;
        free_at = dslot + 2;
        last_m  = w;
      end
    end
  end

  int g_slot[$];
  int g_who[$];

  always @(negedge clk) begin : p_compare
    bit [1:0] xg, xd;
    bit xu, xdn, xb;
    if (!reset_n) begin
      xg = 2'b00; xd = 2'b00; xu = 1'b0; xdn = 1'b0; xb = 1'b0;
    end else begin
      xg  = e_gnt.exists(n)  ? e_gnt[n]  : 2'b00;
      xd  = e_done.exists(n) ? e_done[n] : 2'b00;
      xu  = e_up.exists(n)   ? e_up[n]   : 1'b0;
      xdn = e_down.exists(n) ? e_down[n] : 1'b0;
      xb  = e_busy.exists(n) ? e_busy[n] : 1'b0;
    end
    chk("cyc_gnt",   int'(gnt),      int'(xg));
    chk("cyc_done",  int'(done),     int'(xd));
    chk("cyc_up",    int'(cnt_up),   int'(xu));
    chk("cyc_down",  int'(cnt_down), int'(xdn));
    chk("cyc_busy",  int'(busy),     int'(xb));
    chk("cnt_excl",  int'(cnt_up & cnt_down), 0);
    chk("gnt_1hot",  int'($onehot0(gnt)), 1);
    chk("done_1hot", int'($onehot0(done)), 1);
    if (reset_n && gnt != 2'b00) begin
      g_slot.push_back(n);
      g_who.push_back(gnt[1] ? 1 : 0);
    end
  end

  task automatic wait_gnt(input int max_cyc);
    bit seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (gnt != 2'b00) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL wait_gnt timeout actual=%b required=nonzero", gnt);
    end
  endtask

  task automatic wait_done(input int max_cyc);
    bit seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (done != 2'b00) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL wait_done timeout actual=%b required=nonzero", done);
    end
  endtask

  initial begin : p_stim
    repeat (3) @(negedge clk);
    chk("rst_gnt",  int'(gnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_up",   int'(cnt_up), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Requester 0 counts up 3; inputs changed mid-run must not matter.
    req = 2'b01; dir = 2'b01; steps0 = 3'd3;
    wait_gnt(4);
    chk("s1_gnt", int'(gnt), 1);
    chk("s1_up",  int'(cnt_up), 1);
    req = 2'b00; dir = 2'b00; steps0 = 3'd7;
    wait_done(6);
    chk("s1_done",  int'(done), 1);
    chk("s1_count", int'(count), 3);

    // Requester 1 counts down 2; requester 0 raises and drops req while busy.
    req = 2'b10; dir = 2'b00; steps1 = 3'd2;
    wait_gnt(4);
    chk("s2_gnt",  int'(gnt), 2);
    chk("s2_down", int'(cnt_down), 1);
    req = 2'b01; dir = 2'b01; steps0 = 3'd4;
    @(negedge clk);
    req = 2'b00;
    wait_done(6);
    chk("s2_done",  int'(done), 2);
    chk("s2_count", int'(count), 1);

    // From 1, two down pulses wrap the counter to 7.
    req = 2'b10; dir = 2'b00; steps1 = 3'd2;
    wait_gnt(6);
    req = 2'b00;
    wait_done(6);
    chk("s3_done",  int'(done), 2);
    chk("s3_count", int'(count), 7);

    // Zero steps: grant, done the next cycle, no pulse.
    req = 2'b01; dir = 2'b01; steps0 = 3'd0;
    wait_gnt(6);
    chk("s4_gnt",  int'(gnt), 1);
    chk("s4_up",   int'(cnt_up), 0);
    chk("s4_busy", int'(busy), 1);
    req = 2'b00;
    @(negedge clk);
    chk("s4_done", int'(done), 1);
    chk("s4_up2",  int'(cnt_up), 0);
    @(negedge clk);
    chk("s4_count", int'(count), 7);
    chk("s4_idle",  int'(busy), 0);

    // Both requesting with one step each: strict alternation, 3-cycle spacing.
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    g_slot.delete(); g_who.delete();
    req = 2'b11; dir = 2'b11; steps0 = 3'd1; steps1 = 3'd1;
    wait_gnt(4);
    repeat (10) @(negedge clk);
    req = 2'b00;
    repeat (2) @(negedge clk);
    chk("s5_ngrants", g_who.size(), 4);
    if (g_who.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("s5_order", g_who[i], i % 2);
      for (int i = 1; i < 4; i++) chk("s5_space", g_slot[i] - g_slot[i-1], 3);
    end
    chk("s5_count", int'(count), 4);

    // Reset during the second of five up pulses: everything drops, no done.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    req = 2'b01; dir = 2'b01; steps0 = 3'd5;
    wait_gnt(4);
    req = 2'b00;
    chk("s6_up1", int'(cnt_up), 1);
    @(posedge clk);
    #2;
    chk("s6_up2",   int'(cnt_up), 1);
    chk("s6_count", int'(count), 1);
    reset_n = 1'b0;
    #1;
    chk("s6_rst_gnt",  int'(gnt), 0);
    chk("s6_rst_up",   int'(cnt_up), 0);
    chk("s6_rst_busy", int'(busy), 0);
    chk("s6_rst_done", int'(done), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("s6_nodone", int'(done), 0);
      chk("s6_nobusy", int'(busy), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : p_watchdog
    #20000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/up_down_counter_arbiter.md
UP_DOWN_COUNTER_ARBITER -- requirements
Module: up_down_counter_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter: NREQ, 2, number of requesters; fixed at 2 in this revision.
REQ-003 Parameter: STEP_W, 3, width of the step-count field; equal to the counter width.
REQ-004 Port: clk  in  1  system clock; all state updates on the rising edge.
REQ-005 Port: reset_n  in  1  asynchronous active-low reset.
REQ-006 Port: req  in  NREQ  per-requester request; held high until the matching gnt.
REQ-007 Port: dir  in  NREQ  per-requester direction (1 = up, 0 = down); sampled with req.
REQ-008 Port: steps0, steps1  in  STEP_W each  step count for requester 0 and 1; sampled with req.
REQ-009 Port: gnt  out  NREQ  one-hot, one-cycle grant pulse.
REQ-010 Port: done  out  NREQ  one-hot, one-cycle completion pulse.
REQ-011 Port: busy  out  1  high in every state other than IDLE.
REQ-012 Port: cnt_up, cnt_down  out  1 each  drive the counter's up/down inputs.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 In IDLE with any req high, the FSM SHALL register the winner, its dir and its steps.
- Next cycle: gnt[winner] = 1.
- Next state: RUN if steps != 0, otherwise DONE.
REQ-015 Arbitration SHALL be round-robin with a last-served pointer.
- Single requester: that requester wins.
- Both requesting: the requester that is not last-served wins.
- The pointer SHALL update on entering DONE.
REQ-016 cnt_up (dir = 1) or cnt_down (dir = 0) SHALL be high for exactly `steps` consecutive cycles.
- The first pulse SHALL occur in the same cycle as gnt.
REQ-017 cnt_up and cnt_down SHALL never be high in the same cycle.
REQ-018 After the last pulse, the FSM SHALL enter DONE: done[owner] = 1 for one cycle, then return to IDLE.
REQ-019 The block SHALL sample a new request no earlier than the cycle after done.
- Minimum spacing between two grants: steps + 2 cycles.
REQ-020 steps = 0 SHALL produce gnt, then done on the next cycle, with no cnt pulse.
REQ-021 req, dir and steps changes during RUN or DONE SHALL be ignored; the latched values govern.
REQ-022 A req dropped before its grant SHALL be withdrawn without side effects.
REQ-023 Counter wrap-around (7 to 0, 0 to 7) is the counter's behaviour; the arbiter SHALL NOT detect or prevent it.
REQ-024 All outputs SHALL be registered.

Reset
REQ-025 On reset_n low, asynchronously:
- state = IDLE;
- gnt, done, busy, cnt_up, cnt_down = 0;
- remaining-step counter = 0;
- last-served = 1 (requester 0 wins the first tie).
REQ-026 Reset mid-RUN SHALL end the pulse train immediately and SHALL NOT produce done.
REQ-027 After reset_n rises, the first possible grant SHALL occur one cycle after the first sampled req.

Structure
REQ-028 Package counter_arb_pkg SHALL hold the state enum, NREQ and STEP_W.
REQ-029 Round-robin selection SHALL be a sub-module rr_arbiter2.
- Inputs: req, last.
- Outputs: one-hot win.
REQ-030 The remaining-step down-counter and the FSM SHALL reside in the top module.

Verification
REQ-031 The bench SHALL instantiate the arbiter driving up_down_counter and check count each cycle.
REQ-032 Scenario: from reset, req = 01, dir0 = 1, steps0 = 3 -> gnt = 01, three cnt_up pulses, done = 01, count = 011.
REQ-033 Scenario: count = 001; req = 10, dir1 = 0, steps1 = 2 -> two cnt_down pulses, count = 111 (wrap), done = 10.
REQ-034 Scenario: req = 11 held, steps = 1 each, after reset -> grant order 0, 1, 0, 1; spacing 3 cycles.
REQ-035 Scenario: steps0 = 0, req = 01 -> gnt, then done next cycle, no cnt pulse, count unchanged.
REQ-036 Scenario: reset_n low during the second of 5 up pulses -> outputs 0 at once, no done, busy = 0.
REQ-037 Assertion: cnt_up and cnt_down are never both 1, and gnt and done are each at most one-hot, in every scenario.
